// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a small receive FIFO and sticky error flags.
//
// The serial line is synchronised by two flops. The receiver samples each bit in
// the middle of its bit period. Complete bytes are pushed into a circular FIFO,
// and the CPU reads them with a pop strobe.
//
// Ports:
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset
//   uart_rx_i      asynchronous serial input, idle high
//   data_o         byte at the FIFO head (meaningful while valid_o=1)
//   valid_o        FIFO not empty
//   rd_strobe_i    pop the head entry (ignored while empty)
//   level_o        number of bytes held in the FIFO
//   frame_err_o    sticky: a stop bit was sampled low
//   overrun_err_o  sticky: a byte was dropped because the FIFO was full
//   err_clr_i      clears both sticky flags (a same-edge set wins)
module uart_rx #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUDRATE    = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              uart_rx_i,
    output logic [7:0]                        data_o,
    output logic                              valid_o,
    input  logic                              rd_strobe_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
    output logic                              frame_err_o,
    output logic                              overrun_err_o,
    input  logic                              err_clr_i
);

    localparam int DIV   = CLK_FREQ_HZ / BAUDRATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx: CLK_FREQ_HZ/BAUDRATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_rx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to the idle line level)
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             frame_err_set;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                // Re-check the line half a bit in; a high level means a glitch.
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    shift_d[bit_q] = rx_s_q;
                    cnt_d          = '0;
                    bit_d          = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                // Park here during a break so it reports a single frame error.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             full;
    logic             empty;
    logic             pop;
    logic             wr_en;
    logic             overrun_set;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign pop   = rd_strobe_i && !empty;
    // A full FIFO still accepts a byte when the head is popped on the same edge.
    assign wr_en       = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags (set beats clear)
    // ------------------------------------------------------------------
    logic frame_err_q;
    logic overrun_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_err_set | (frame_err_q & ~err_clr_i);
            overrun_err_q <= overrun_set | (overrun_err_q & ~err_clr_i);
        end
    end

    assign data_o        = mem_q[rd_ptr_q];
    assign valid_o       = !empty;
    assign level_o       = level_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_err_q;

endmodule
